shift_mix_add_round: RTL

AES round back-end stage: accepts the 128-bit SubBytes result plus the round key, applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey, and holds the result in a ready/valid output register. It sits directly downstream of the SubBytes stage in the encryption datapath. Its output feeds the next round's SubBytes input or, when `out_last` is set, the ciphertext sink.

---
 rtl/shift_mix_add_round_if.sv | 24 ++
 rtl/shift_mix_add_round.sv | 123 ++++++++++++
 2 files changed

// File: rtl/shift_mix_add_round_if.sv
// Handshake and data bundle for the AES round back-end stage.
// The master side (upstream producer plus downstream consumer) drives the
// input block and out_ready; the slave side is the round stage itself.
interface shift_mix_add_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic [0:127] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_key, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_key, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/shift_mix_add_round.sv
// AES round back-end: ShiftRows, MixColumns (skipped on the final round) and
// AddRoundKey, with a ready/valid output register.
// Optional macro SMA_PIPE2_EN inserts a register stage between the
// ShiftRows/MixColumns logic and AddRoundKey (2-cycle latency, full rate).
module shift_mix_add_round (
    input logic                  clk,
    input logic                  rst_n,
    shift_mix_add_round_if.slave bus_io
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] mix_column(input logic [0:31] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    logic [0:127] shifted;
    logic [0:127] mixed;
    logic [0:127] round_state;
    logic         accept;

    logic [0:127] data_d, data_q;
    logic         last_q;
    logic         valid_q;

    // ShiftRows then MixColumns; the final round bypasses the column mix.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(r+4*c) +: 8] = bus_io.in_data[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
        end
        round_state = bus_io.in_last ? shifted : mixed;
    end

    assign bus_io.out_valid = valid_q;
    assign bus_io.out_data  = data_q;
    assign bus_io.out_last  = last_q;
    assign accept           = bus_io.in_valid && bus_io.in_ready;

`ifdef SMA_PIPE2_EN
    logic         s1_valid_q;
    logic [0:127] s1_state_q;
    logic [0:127] s1_key_q;
    logic         s1_last_q;
    logic         s2_ready;

    assign s2_ready        = !valid_q || bus_io.out_ready;
    assign bus_io.in_ready = !s1_valid_q || s2_ready;
    assign data_d          = s1_state_q ^ s1_key_q;

    // Stage 1: mixed state plus the key/last accepted with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_state_q <= '0;
            s1_key_q   <= '0;
            s1_last_q  <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_state_q <= round_state;
            s1_key_q   <= bus_io.in_key;
            s1_last_q  <= bus_io.in_last;
        end else if (s2_ready) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: AddRoundKey into the output register; data holds when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (s2_ready) begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q <= data_d;
                last_q <= s1_last_q;
            end
        end
    end
`else
    assign bus_io.in_ready = !valid_q || bus_io.out_ready;
    assign data_d          = round_state ^ bus_io.in_key;

    // Output register: load on accept, otherwise drain on consumer ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            last_q  <= bus_io.in_last;
        end else if (bus_io.out_ready) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule
